// File: rtl/mux_demux_unit.sv
// Constant-data 2:1 and 4:1 multiplexers plus a 1:2 demultiplexer, each with its own select.
// REG_OUT=0 gives purely combinational outputs; REG_OUT=1 adds one output register stage.
module mux_demux_unit #(
    parameter int         REG_OUT = 0,
    parameter logic       M2_D0   = 1'b0,
    parameter logic       M2_D1   = 1'b1,
    parameter logic [1:0] M4_D0   = 2'd0,
    parameter logic [1:0] M4_D1   = 2'd1,
    parameter logic [1:0] M4_D2   = 2'd2,
    parameter logic [1:0] M4_D3   = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mux_2to1_sel,
    output logic       mux_2to1_out,
    input  logic [1:0] mux_4to1_sel,
    output logic [1:0] mux_4to1_out,
    input  logic       demux_1to2_in,
    input  logic       demux_1to2_sel,
    output logic [1:0] demux_1to2_out
);

    logic       m2_d;
    logic [1:0] m4_d;
    logic [1:0] dm_d;

    // Ternary trees propagate X from an unknown select in simulation.
    always_comb begin
        m2_d = mux_2to1_sel ? M2_D1 : M2_D0;
        m4_d = mux_4to1_sel[1] ? (mux_4to1_sel[0] ? M4_D3 : M4_D2)
                               : (mux_4to1_sel[0] ? M4_D1 : M4_D0);
        dm_d = {demux_1to2_sel & demux_1to2_in, ~demux_1to2_sel & demux_1to2_in};
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic       m2_q;
            logic [1:0] m4_q;
            logic [1:0] dm_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m2_q <= 1'b0;
                    m4_q <= 2'b00;
                    dm_q <= 2'b00;
                end else begin
                    m2_q <= m2_d;
                    m4_q <= m4_d;
                    dm_q <= dm_d;
                end
            end

            assign mux_2to1_out   = m2_q;
            assign mux_4to1_out   = m4_q;
            assign demux_1to2_out = dm_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign mux_2to1_out   = m2_d;
            assign mux_4to1_out   = m4_d;
            assign demux_1to2_out = dm_d;
        end
    endgenerate

endmodule

// File: tb/tb_mux_demux_unit.sv
// Bench for mux_demux_unit: combinational default build, registered build and a build with
// reversed 4:1 data, all driven from the same select/data inputs.
module tb_mux_demux_unit;

    localparam logic [1:0] DEF_M2 = 2'b10;          // index 0 -> 0, index 1 -> 1
    localparam logic [7:0] DEF_M4 = 8'b11_10_01_00; // index i -> i
    localparam logic [1:0] P_M2   = 2'b01;          // index 0 -> 1, index 1 -> 0
    localparam logic [7:0] P_M4   = 8'b00_01_10_11; // index i -> 3-i

    logic       clk = 1'b0;
    logic       rst;
    logic       s2;
    logic [1:0] s4;
    logic       din;
    logic       dsel;

    logic       c_m2, r_m2, p_m2;
    logic [1:0] c_m4, r_m4, p_m4;
    logic [1:0] c_dm, r_dm, p_dm;

    wire [4:0] c_o = {c_m2, c_m4, c_dm};
    wire [4:0] r_o = {r_m2, r_m4, r_dm};
    wire [4:0] p_o = {p_m2, p_m4, p_dm};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_demux_unit #(.REG_OUT(0)) u_comb (
        .clk(clk), .rst(rst),
        .mux_2to1_sel(s2), .mux_2to1_out(c_m2),
        .mux_4to1_sel(s4), .mux_4to1_out(c_m4),
        .demux_1to2_in(din), .demux_1to2_sel(dsel), .demux_1to2_out(c_dm)
    );

    mux_demux_unit #(.REG_OUT(1)) u_reg (
        .clk(clk), .rst(rst),
        .mux_2to1_sel(s2), .mux_2to1_out(r_m2),
        .mux_4to1_sel(s4), .mux_4to1_out(r_m4),
        .demux_1to2_in(din), .demux_1to2_sel(dsel), .demux_1to2_out(r_dm)
    );

    mux_demux_unit #(
        .REG_OUT(0), .M2_D0(1'b1), .M2_D1(1'b0),
        .M4_D0(2'd3), .M4_D1(2'd2), .M4_D2(2'd1), .M4_D3(2'd0)
    ) u_par (
        .clk(clk), .rst(rst),
        .mux_2to1_sel(s2), .mux_2to1_out(p_m2),
        .mux_4to1_sel(s4), .mux_4to1_out(p_m4),
        .demux_1to2_in(din), .demux_1to2_sel(dsel), .demux_1to2_out(p_dm)
    );

    // Reference: table lookups for the muxes, shift-by-select for the demux.
    function automatic logic [4:0] model(input logic [1:0] m2tab, input logic [7:0] m4tab,
                                         input logic a, input logic [1:0] b,
                                         input logic di, input logic ds);
        logic [1:0] dm;
        dm = 2'({1'b0, di} << ds);
        return {m2tab[a], m4tab[int'(b) * 2 +: 2], dm};
    endfunction

    task automatic set_in(input logic a, input logic [1:0] b, input logic di, input logic ds);
        s2 = a; s4 = b; din = di; dsel = ds;
    endtask

    task automatic test_reset;
        logic [4:0] e;
        rst = 1'b1;
        set_in(1'b0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (r_o !== 5'b0) begin errors++; $display("FAIL reset_async: got %b want %b", r_o, 5'b0); end
        @(posedge clk); #1;
        checks++;
        if (r_o !== 5'b0) begin errors++; $display("FAIL reset_hold: got %b want %b", r_o, 5'b0); end
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, 2'd3, 1'b1, 1'b1);
        #1;
        checks++;
        if (r_o !== 5'b0) begin errors++; $display("FAIL reset_release_noclk: got %b want %b", r_o, 5'b0); end
        e = model(DEF_M2, DEF_M4, 1'b1, 2'd3, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (r_o !== e) begin errors++; $display("FAIL reset_first_capture: got %b want %b", r_o, e); end
    endtask

    task automatic test_directed;
        logic [4:0] e;
        logic [4:0] vec [6];
        vec[0] = 5'b0_00_1_0; // {s2, s4, din, dsel}
        vec[1] = 5'b1_01_1_1;
        vec[2] = 5'b0_10_1_0;
        vec[3] = 5'b1_11_1_1;
        vec[4] = 5'b0_00_0_0;
        vec[5] = 5'b0_00_0_1;
        for (int i = 0; i < 6; i++) begin
            set_in(vec[i][4], vec[i][3:2], vec[i][1], vec[i][0]);
            #1;
            e = model(DEF_M2, DEF_M4, s2, s4, din, dsel);
            checks++;
            if (c_o !== e) begin errors++; $display("FAIL directed_comb[%0d]: got %b want %b", i, c_o, e); end
        end
        // Explicit expectations from the listed cases.
        set_in(1'b1, 2'd1, 1'b1, 1'b1); #1;
        checks++;
        if (c_o !== 5'b1_01_10) begin errors++; $display("FAIL directed_all_one: got %b want %b", c_o, 5'b1_01_10); end
        set_in(1'b0, 2'd0, 1'b1, 1'b0); #1;
        checks++;
        if (c_o !== 5'b0_00_01) begin errors++; $display("FAIL directed_all_zero: got %b want %b", c_o, 5'b0_00_01); end
    endtask

    task automatic test_demux_zero;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 2'd0, 1'b0, i[0]);
            #1;
            checks++;
            if (c_dm !== 2'b00) begin errors++; $display("FAIL demux_zero[%0d]: got %b want %b", i, c_dm, 2'b00); end
        end
    endtask

    task automatic test_param_sweep;
        logic [1:0] want;
        for (int i = 0; i < 4; i++) begin
            set_in(i[0], i[1:0], 1'b1, i[0]);
            #1;
            want = 2'(3 - i);
            checks++;
            if (p_m4 !== want || p_m2 !== ~i[0]) begin
                errors++;
                $display("FAIL param_sweep[%0d]: got m4=%0d m2=%b want m4=%0d m2=%b", i, p_m4, p_m2, want, ~i[0]);
            end
        end
    endtask

    task automatic test_random;
        logic [4:0] ec, ep;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            set_in(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
            #1;
            ec = model(DEF_M2, DEF_M4, s2, s4, din, dsel);
            ep = model(P_M2, P_M4, s2, s4, din, dsel);
            checks++;
            if (c_o !== ec) begin errors++; $display("FAIL rand_comb[%0d]: got %b want %b", i, c_o, ec); end
            checks++;
            if (p_o !== ep) begin errors++; $display("FAIL rand_param[%0d]: got %b want %b", i, p_o, ep); end
            @(posedge clk); #1;
            checks++;
            if (r_o !== ec) begin errors++; $display("FAIL rand_reg[%0d]: got %b want %b", i, r_o, ec); end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] prev, nxt;
        @(negedge clk);
        set_in(1'b0, 2'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        prev = model(DEF_M2, DEF_M4, 1'b0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        set_in(1'b1, 2'd2, 1'b1, 1'b1);
        nxt = model(DEF_M2, DEF_M4, 1'b1, 2'd2, 1'b1, 1'b1);
        #1;
        checks++;
        if (r_o !== prev) begin errors++; $display("FAIL latency_hold: got %b want %b", r_o, prev); end
        checks++;
        if (c_o !== nxt) begin errors++; $display("FAIL latency_comb: got %b want %b", c_o, nxt); end
        @(posedge clk); #1;
        checks++;
        if (r_o !== nxt) begin errors++; $display("FAIL latency_update: got %b want %b", r_o, nxt); end
    endtask

    task automatic test_rst_midrun;
        logic [4:0] e;
        @(negedge clk);
        set_in(1'b1, 2'd3, 1'b1, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (r_o !== 5'b0) begin errors++; $display("FAIL midrun_rst_async: got %b want %b", r_o, 5'b0); end
        @(posedge clk); #1;
        checks++;
        if (r_o !== 5'b0) begin errors++; $display("FAIL midrun_rst_hold: got %b want %b", r_o, 5'b0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (r_o !== 5'b0) begin errors++; $display("FAIL midrun_release_noclk: got %b want %b", r_o, 5'b0); end
        e = model(DEF_M2, DEF_M4, 1'b1, 2'd3, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (r_o !== e) begin errors++; $display("FAIL midrun_recapture: got %b want %b", r_o, e); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_demux_zero();
        test_param_sweep();
        test_random();
        test_back_to_back();
        test_rst_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
